// File: rtl/timer_pkg.sv
// Shared register offsets, reset constants and byte-lane merge helper for the machine timer.
package timer_pkg;

    localparam logic [4:0] OFFSET_MTIME     = 5'h00;
    localparam logic [4:0] OFFSET_MTIMEH    = 5'h04;
    localparam logic [4:0] OFFSET_MTIMECMP  = 5'h08;
    localparam logic [4:0] OFFSET_MTIMECMPH = 5'h0C;
    localparam logic [4:0] OFFSET_MSIP      = 5'h10;
    localparam logic [4:0] OFFSET_PRESCALE  = 5'h14;

    // All-ones compare value keeps mtip low out of reset.
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_value,
        input logic [31:0] new_value,
        input logic [3:0]  lanes
    );
        logic [31:0] result;
        result = old_value;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                result[8*i +: 8] = new_value[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider: counts 0..prescale and fires tick on the terminal count; clear restarts it with no tick.
// Tick is combinational from the counter; no backpressure.
module timer_prescaler #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      clear,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] count;
    logic                      terminal;

    assign terminal = (count == prescale);
    assign tick     = terminal && !clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || terminal) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped mtime/mtimecmp/msip with prescaled tick and a tear-free high-half shadow of mtime.
// Reads respond 1 cycle after accept; bus_ready is high whenever out of reset, so no request stalls.
module machine_timer
    import timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        bus_valid,
    output logic        bus_ready,
    input  logic        bus_write,
    input  logic [4:0]  bus_address,
    input  logic [3:0]  bus_byte_enable,
    input  logic [31:0] bus_write_value,
    output logic        bus_read_valid,
    output logic [31:0] bus_read_value,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        mtip,
    output logic        msip
);

    localparam logic [2:0] SEL_MTIME     = OFFSET_MTIME[4:2];
    localparam logic [2:0] SEL_MTIMEH    = OFFSET_MTIMEH[4:2];
    localparam logic [2:0] SEL_MTIMECMP  = OFFSET_MTIMECMP[4:2];
    localparam logic [2:0] SEL_MTIMECMPH = OFFSET_MTIMECMPH[4:2];
    localparam logic [2:0] SEL_MSIP      = OFFSET_MSIP[4:2];
    localparam logic [2:0] SEL_PRESCALE  = OFFSET_PRESCALE[4:2];

    logic [2:0]                sel;
    logic                      accept;
    logic                      wr_en;
    logic                      rd_en;
    logic                      wr_mtime_lo;
    logic                      wr_mtime_hi;
    logic                      wr_cmp_lo;
    logic                      wr_cmp_hi;
    logic                      wr_msip;
    logic                      wr_prescale;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [31:0]               prescale_merged;
    logic                      tick;
    logic [31:0]               shadow;
    logic                      shadow_valid;
    logic [31:0]               read_word;
    logic                      unused_bits;

    assign bus_ready = reset_n;
    assign accept    = bus_valid && bus_ready;
    assign sel       = bus_address[4:2];
    assign wr_en     = accept && bus_write;
    assign rd_en     = accept && !bus_write;

    assign wr_mtime_lo = wr_en && (sel == SEL_MTIME);
    assign wr_mtime_hi = wr_en && (sel == SEL_MTIMEH);
    assign wr_cmp_lo   = wr_en && (sel == SEL_MTIMECMP);
    assign wr_cmp_hi   = wr_en && (sel == SEL_MTIMECMPH);
    assign wr_msip     = wr_en && (sel == SEL_MSIP) && bus_byte_enable[0];
    assign wr_prescale = wr_en && (sel == SEL_PRESCALE);

    // Lanes above the prescale width are accepted on the bus but have nowhere to land.
    assign prescale_merged = merge_lanes(32'(prescale), bus_write_value, bus_byte_enable);
    assign unused_bits     = ^{bus_address[1:0], prescale_merged[31:PRESCALE_WIDTH]};

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .prescale(prescale),
        .clear   (wr_prescale),
        .tick    (tick)
    );

    always_comb begin
        read_word = '0;
        case (sel)
            SEL_MTIME:     read_word = mtime[31:0];
            SEL_MTIMEH:    read_word = shadow_valid ? shadow : mtime[63:32];
            SEL_MTIMECMP:  read_word = mtimecmp[31:0];
            SEL_MTIMECMPH: read_word = mtimecmp[63:32];
            SEL_MSIP:      read_word = {31'd0, msip};
            SEL_PRESCALE:  read_word = 32'(prescale);
            default:       read_word = '0;
        endcase
    end

    // A software write to either mtime half wins over a coincident tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mtime <= '0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= merge_lanes(mtime[31:0], bus_write_value, bus_byte_enable);
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= merge_lanes(mtime[63:32], bus_write_value, bus_byte_enable);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mtimecmp <= MTIMECMP_RESET;
            prescale <= '0;
            msip     <= 1'b0;
            mtip     <= 1'b0;
        end else begin
            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= merge_lanes(mtimecmp[31:0], bus_write_value, bus_byte_enable);
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], bus_write_value, bus_byte_enable);
            end
            if (wr_prescale) begin
                prescale <= prescale_merged[PRESCALE_WIDTH-1:0];
            end
            if (wr_msip) begin
                msip <= bus_write_value[0];
            end
            mtip <= (mtime >= mtimecmp);
        end
    end

    // Low-half read snapshots the high half so a following high-half read cannot tear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow       <= '0;
            shadow_valid <= 1'b0;
        end else if (rd_en && (sel == SEL_MTIME)) begin
            shadow       <= mtime[63:32];
            shadow_valid <= 1'b1;
        end else if ((rd_en && (sel == SEL_MTIMEH)) || wr_mtime_lo || wr_mtime_hi) begin
            shadow_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus_read_valid <= 1'b0;
            bus_read_value <= '0;
        end else begin
            bus_read_valid <= rd_en;
            if (rd_en) begin
                bus_read_value <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: register table, hand-built timing sequences, then random traffic vs a reference model.
module tb_machine_timer;

    localparam int PW = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_write;
    logic [4:0]  bus_address;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_write_value;
    logic        bus_read_valid;
    logic [31:0] bus_read_value;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        mtip;
    logic        msip;

    always #5 clock = ~clock;

    machine_timer #(.PRESCALE_WIDTH(PW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus_valid      (bus_valid),
        .bus_ready      (bus_ready),
        .bus_write      (bus_write),
        .bus_address    (bus_address),
        .bus_byte_enable(bus_byte_enable),
        .bus_write_value(bus_write_value),
        .bus_read_valid (bus_read_valid),
        .bus_read_value (bus_read_value),
        .mtime          (mtime),
        .mtimecmp       (mtimecmp),
        .mtip           (mtip),
        .msip           (msip)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_mtip;
    logic        m_msip;
    int          m_pre;
    longint      m_since;
    logic [31:0] m_shadow;
    logic        m_shv;
    logic        m_rvld;
    logic [31:0] m_rdata;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    task automatic model_reset();
        m_mtime  = '0;
        m_cmp    = '1;
        m_mtip   = 1'b0;
        m_msip   = 1'b0;
        m_pre    = 0;
        m_since  = 0;
        m_shadow = '0;
        m_shv    = 1'b0;
        m_rvld   = 1'b0;
        m_rdata  = '0;
    endtask

    // One clock edge of the architectural rules, using values from before the edge.
    task automatic model_edge();
        logic rd;
        logic wr;
        logic tick;
        int   w;
        rd   = bus_valid && !bus_write;
        wr   = bus_valid && bus_write;
        w    = int'(bus_address >> 2);
        tick = ((m_since % longint'(m_pre + 1)) == longint'(m_pre)) && !(wr && w == 5);
        m_rvld = rd;
        if (rd) begin
            case (w)
                0:       m_rdata = m_mtime[31:0];
                1:       m_rdata = m_shv ? m_shadow : m_mtime[63:32];
                2:       m_rdata = m_cmp[31:0];
                3:       m_rdata = m_cmp[63:32];
                4:       m_rdata = {31'd0, m_msip};
                5:       m_rdata = 32'(m_pre);
                default: m_rdata = '0;
            endcase
        end
        m_mtip = (m_mtime >= m_cmp);
        if (rd && w == 0) begin
            m_shadow = m_mtime[63:32];
            m_shv    = 1'b1;
        end else if (rd && w == 1) begin
            m_shv = 1'b0;
        end
        if (wr && w == 0) begin
            m_mtime[31:0] = lanes(m_mtime[31:0], bus_write_value, bus_byte_enable);
            m_shv = 1'b0;
        end else if (wr && w == 1) begin
            m_mtime[63:32] = lanes(m_mtime[63:32], bus_write_value, bus_byte_enable);
            m_shv = 1'b0;
        end else if (tick) begin
            m_mtime = m_mtime + 64'd1;
        end
        if (wr && w == 2) m_cmp[31:0]  = lanes(m_cmp[31:0], bus_write_value, bus_byte_enable);
        if (wr && w == 3) m_cmp[63:32] = lanes(m_cmp[63:32], bus_write_value, bus_byte_enable);
        if (wr && w == 4 && bus_byte_enable[0]) m_msip = bus_write_value[0];
        if (wr && w == 5) begin
            m_pre   = int'(lanes(32'(m_pre), bus_write_value, bus_byte_enable) & ((32'd1 << PW) - 1));
            m_since = 0;
        end else begin
            m_since = m_since + 1;
        end
    endtask

    task automatic check_all();
        chk("mtime", mtime, m_mtime);
        chk("mtimecmp", mtimecmp, m_cmp);
        chk("mtip", 64'(mtip), 64'(m_mtip));
        chk("msip", 64'(msip), 64'(m_msip));
        chk("read_valid", 64'(bus_read_valid), 64'(m_rvld));
        chk("read_value", 64'(bus_read_value), 64'(m_rdata));
        chk("ready", 64'(bus_ready), 64'd1);
    endtask

    task automatic step(input logic v, input logic w, input logic [4:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        bus_valid       = v;
        bus_write       = w;
        bus_address     = a;
        bus_byte_enable = be;
        bus_write_value = d;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, 4'hF, d);
    endtask

    task automatic rd(input logic [4:0] a);
        step(1'b1, 1'b0, a, 4'h0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'h0, 4'h0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mtime"}, mtime, 64'd0);
        chk({tag, "_mtimecmp"}, mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, "_mtip"}, 64'(mtip), 64'd0);
        chk({tag, "_msip"}, 64'(msip), 64'd0);
        chk({tag, "_rvalid"}, 64'(bus_read_valid), 64'd0);
        chk({tag, "_rvalue"}, 64'(bus_read_value), 64'd0);
        chk({tag, "_ready"}, 64'(bus_ready), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'h08, 4'hF, 32'h1122_3344, 32'h0};
        tbl[1]  = '{1'b1, 5'h0C, 4'h3, 32'hAABB_CCDD, 32'h0};
        tbl[2]  = '{1'b0, 5'h08, 4'h0, 32'h0,         32'h1122_3344};
        tbl[3]  = '{1'b0, 5'h0C, 4'h0, 32'h0,         32'hFFFF_CCDD};
        tbl[4]  = '{1'b1, 5'h08, 4'h4, 32'h0055_0000, 32'h0};
        tbl[5]  = '{1'b0, 5'h08, 4'h0, 32'h0,         32'h1155_3344};
        tbl[6]  = '{1'b1, 5'h10, 4'h1, 32'h0000_0001, 32'h0};
        tbl[7]  = '{1'b0, 5'h10, 4'h0, 32'h0,         32'h0000_0001};
        tbl[8]  = '{1'b1, 5'h10, 4'h0, 32'h0000_0000, 32'h0};
        tbl[9]  = '{1'b0, 5'h10, 4'h0, 32'h0,         32'h0000_0001};
        tbl[10] = '{1'b1, 5'h10, 4'hE, 32'h0000_0000, 32'h0};
        tbl[11] = '{1'b0, 5'h10, 4'h0, 32'h0,         32'h0000_0001};
        tbl[12] = '{1'b1, 5'h10, 4'h1, 32'hFFFF_FFFE, 32'h0};
        tbl[13] = '{1'b0, 5'h10, 4'h0, 32'h0,         32'h0000_0000};
        tbl[14] = '{1'b1, 5'h14, 4'hF, 32'hFFFF_FF05, 32'h0};
        tbl[15] = '{1'b0, 5'h14, 4'h0, 32'h0,         32'h0000_0005};
        tbl[16] = '{1'b1, 5'h14, 4'h2, 32'h0000_0700, 32'h0};
        tbl[17] = '{1'b0, 5'h14, 4'h0, 32'h0,         32'h0000_0005};
        tbl[18] = '{1'b1, 5'h14, 4'hF, 32'h0000_0000, 32'h0};
        tbl[19] = '{1'b1, 5'h18, 4'hF, 32'hDEAD_BEEF, 32'h0};
        tbl[20] = '{1'b0, 5'h18, 4'h0, 32'h0,         32'h0000_0000};
        tbl[21] = '{1'b0, 5'h1C, 4'h0, 32'h0,         32'h0000_0000};
        tbl[22] = '{1'b1, 5'h0C, 4'hF, 32'hFFFF_FFFF, 32'h0};
        tbl[23] = '{1'b1, 5'h08, 4'hF, 32'hFFFF_FFFF, 32'h0};
        tbl[24] = '{1'b0, 5'h14, 4'h0, 32'h0,         32'h0000_0000};
        tbl[25] = '{1'b0, 5'h0B, 4'h0, 32'h0,         32'hFFFF_FFFF};

        reset_n         = 1'b0;
        bus_valid       = 1'b0;
        bus_write       = 1'b0;
        bus_address     = '0;
        bus_byte_enable = '0;
        bus_write_value = '0;
        model_reset();
        #22;
        check_reset_outputs("rst");
        reset_n = 1'b1;

        // Out of reset: prescale 0 ticks every cycle, compare register is all ones
        idle(10);
        chk("a_mtime10", mtime, 64'd10);
        rd(5'h08);
        chk("a_cmp_lo", 64'(bus_read_value), 64'hFFFF_FFFF);
        rd(5'h0C);
        chk("a_cmp_hi", 64'(bus_read_value), 64'hFFFF_FFFF);
        chk("a_mtip", 64'(mtip), 64'd0);

        for (int i = 0; i < 26; i++) begin
            step(1'b1, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].data);
            if (!tbl[i].wr) chk($sformatf("tbl%0d", i), 64'(bus_read_value), 64'(tbl[i].exp));
        end

        // Prescale 3: one tick every 4 cycles
        wr(5'h14, 32'd3);
        wr(5'h04, 32'd0);
        wr(5'h00, 32'd100);
        chk("b_start", mtime, 64'd100);
        idle(1);
        chk("b_hold", mtime, 64'd100);
        idle(1);
        chk("b_first_tick", mtime, 64'd101);
        idle(38);
        chk("b_after40", mtime, 64'd110);

        // Writes coincident with a tick land exactly
        idle(1);
        wr(5'h00, 32'h0000_0ABC);
        chk("f_tick_p3", mtime, 64'h0000_0ABC);
        wr(5'h14, 32'd0);
        wr(5'h00, 32'h1234_5678);
        chk("f_tick_p0", mtime, 64'h1234_5678);

        // Carry into the high half, then shadow reads
        wr(5'h04, 32'd0);
        wr(5'h00, 32'hFFFF_FFFE);
        chk("c_start", mtime, 64'h0000_0000_FFFF_FFFE);
        idle(2);
        chk("c_carry", mtime, 64'h0000_0001_0000_0000);
        rd(5'h00);
        chk("c_lo_read", 64'(bus_read_value), 64'd0);
        idle(5);
        rd(5'h04);
        chk("c_hi_shadow", 64'(bus_read_value), 64'd1);
        wr(5'h04, 32'd0);
        wr(5'h00, 32'hFFFF_FFF0);
        rd(5'h00);
        chk("c2_lo_read", 64'(bus_read_value), 64'hFFFF_FFF0);
        idle(20);
        rd(5'h04);
        chk("c2_hi_shadow", 64'(bus_read_value), 64'd0);
        rd(5'h04);
        chk("c2_hi_live", 64'(bus_read_value), 64'd1);

        // mtip rises 6 cycles after mtime write, falls one cycle after compare moves away
        wr(5'h04, 32'd0);
        wr(5'h08, 32'd20);
        wr(5'h0C, 32'd0);
        wr(5'h00, 32'd15);
        for (int k = 1; k <= 6; k++) begin
            idle(1);
            chk($sformatf("d_mtip_c%0d", k), 64'(mtip), (k == 6) ? 64'd1 : 64'd0);
        end
        wr(5'h0C, 32'd1);
        idle(1);
        chk("d_mtip_fall", 64'(mtip), 64'd0);

        // msip lane handling
        step(1'b1, 1'b1, 5'h10, 4'b0001, 32'd1);
        chk("e_msip_set", 64'(msip), 64'd1);
        step(1'b1, 1'b1, 5'h10, 4'b0000, 32'd0);
        chk("e_msip_hold", 64'(msip), 64'd1);
        step(1'b1, 1'b1, 5'h10, 4'b0001, 32'd0);
        chk("e_msip_clr", 64'(msip), 64'd0);

        // Reset while a read response is outstanding
        bus_valid       = 1'b1;
        bus_write       = 1'b0;
        bus_address     = 5'h08;
        bus_byte_enable = 4'h0;
        @(posedge clock);
        model_edge();
        #1;
        chk("g_rvalid_pre", 64'(bus_read_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("g_async");
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("g_held");
        bus_valid = 1'b0;
        reset_n   = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic        v;
            logic        w;
            logic [4:0]  a;
            logic [3:0]  be;
            logic [31:0] d;
            v  = ($urandom_range(0, 9) < 7);
            w  = 1'($urandom_range(0, 1));
            a  = 5'($urandom_range(0, 31));
            be = 4'($urandom);
            case (a[4:2])
                3'd1, 3'd3: d = $urandom_range(0, 1);
                3'd5:       d = $urandom_range(0, 3);
                3'd0, 3'd2: d = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
                default:    d = $urandom;
            endcase
            step(v, w, a, be, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
